// File: rtl/wb_stage_pkg.sv
// Shared opcode/funct constants, state encoding and decode helpers for the writeback stage.
package wb_stage_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JALR   = 6'h09;

  typedef enum logic {S_IDLE, S_WAIT_MEM} wb_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
  endfunction

  // Non-load ops that produce a register result in the cycle after accept.
  function automatic logic writes_reg(input logic [5:0] op);
    return op inside {OP_R_FORM, OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                      OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  endfunction

  function automatic logic is_link(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_JAL) || (op == OP_R_FORM && funct == FN_JALR);
  endfunction

  function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (op == OP_JAL)         return 5'd31;
    else if (op == OP_R_FORM) return rd;
    else                      return rt;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data lane select and sign/zero extension.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (off)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (op)
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'h0, lane_b};
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'h0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one registered register-file write port fed by retired results and load returns.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_res,
  input  logic [31:0] next_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err,
  output logic [31:0] retire_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  wb_state_e   state;
  logic [7:0]  timer;
  logic [4:0]  ld_dest;
  logic [5:0]  ld_op;
  logic [1:0]  ld_off;

  logic [4:0]  dest;
  logic [31:0] alu_wdata;
  logic [31:0] ld_data;
  logic        tmo_hit;

  assign in_ready  = (state == S_IDLE);
  assign dest      = dest_of(op, rt, rd);
  assign alu_wdata = is_link(op, funct) ? next_pc : alu_res;
  assign tmo_hit   = (timer == TMO_LAST);

  wb_load_align u_align (
    .op    (ld_op),
    .off   (ld_off),
    .rdata (mem_rdata),
    .data  (ld_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      timer   <= 8'd0;
      ld_dest <= 5'd0;
      ld_op   <= 6'd0;
      ld_off  <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_load(op)) begin
              ld_dest <= dest;
              ld_op   <= op;
              ld_off  <= alu_res[1:0];
              timer   <= 8'd0;
              state   <= S_WAIT_MEM;
            end else if (writes_reg(op) && dest != 5'd0) begin
              wr_en   <= 1'b1;
              wr_addr <= dest;
              wr_data <= alu_wdata;
            end
          end
        end
        S_WAIT_MEM: begin
          // A return on the final timeout cycle still completes the load.
          if (mem_rvalid) begin
            if (ld_dest != 5'd0) begin
              wr_en   <= 1'b1;
              wr_addr <= ld_dest;
              wr_data <= ld_data;
            end
            state <= S_IDLE;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire_pulse;

  assign retire_pulse = (state == S_IDLE && in_valid && !is_load(op)) ||
                        (state == S_WAIT_MEM && (mem_rvalid || tmo_hit));

  always_ff @(posedge CLK) begin
    if (RST)               retire_cnt <= 32'd0;
    else if (retire_pulse) retire_cnt <= retire_cnt + 32'd1;
  end
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: vector table for single-cycle writes plus
// hand-written load, timeout, reset and retire-count sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_res;
  logic [31:0] next_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct(funct), .rt(rt), .rd(rd), .alu_res(alu_res), .next_pc(next_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .retire_cnt(retire_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] next_pc;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_data;
  } ld_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] pc);
    in_valid = 1'b1; op = o; funct = f; rt = t; rd = d; alu_res = a; next_pc = pc;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; op = 6'h3F; funct = 6'h00; rt = 5'd0; rd = 5'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  vec_t vecs[10];
  ld_t  lds[7];

  initial begin
    vecs[0] = '{"rform_add",  OP_R_FORM, 6'h20,   5'd1,  5'd8,  32'h0000_0010, 32'h0,         1'b1, 5'd8,  32'h0000_0010};
    vecs[1] = '{"jal",        OP_JAL,    6'h00,   5'd5,  5'd6,  32'hDEAD_BEEF, 32'h0040_0008, 1'b1, 5'd31, 32'h0040_0008};
    vecs[2] = '{"rform_rd0",  OP_R_FORM, 6'h20,   5'd3,  5'd0,  32'h1111_1111, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[3] = '{"jalr",       OP_R_FORM, FN_JALR, 5'd2,  5'd4,  32'h0000_DEAD, 32'h0000_1234, 1'b1, 5'd4,  32'h0000_1234};
    vecs[4] = '{"addi",       OP_ADDI,   6'h3F,   5'd3,  5'd9,  32'hFFFF_FFFE, 32'h0,         1'b1, 5'd3,  32'hFFFF_FFFE};
    vecs[5] = '{"ori_rt0",    OP_ORI,    6'h00,   5'd0,  5'd7,  32'h0000_00FF, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[6] = '{"sw",         OP_SW,     6'h00,   5'd7,  5'd7,  32'h0000_0100, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[7] = '{"beq",        OP_BEQ,    6'h00,   5'd6,  5'd6,  32'h0000_0001, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[8] = '{"unknown",    6'h3F,     6'h00,   5'd5,  5'd5,  32'h0000_0002, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[9] = '{"xori",       OP_XORI,   6'h00,   5'd30, 5'd1,  32'h0000_A5A5, 32'h0,         1'b1, 5'd30, 32'h0000_A5A5};

    lds[0] = '{"lb_off3",  OP_LB,  5'd9,  32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80};
    lds[1] = '{"lbu_off3", OP_LBU, 5'd9,  32'h0000_1003, 32'h80FF_0011, 32'h0000_0080};
    lds[2] = '{"lh_off2",  OP_LH,  5'd10, 32'h0000_1002, 32'h80FF_0011, 32'hFFFF_80FF};
    lds[3] = '{"lhu_off0", OP_LHU, 5'd11, 32'h0000_1000, 32'h80FF_0011, 32'h0000_0011};
    lds[4] = '{"lb_off1",  OP_LB,  5'd12, 32'h0000_1001, 32'h80FF_0011, 32'h0000_0000};
    lds[5] = '{"lb_off2",  OP_LB,  5'd13, 32'h0000_1002, 32'h80FF_0011, 32'hFFFF_FFFF};
    lds[6] = '{"lw_off2",  OP_LW,  5'd14, 32'h0000_1002, 32'h1234_5678, 32'h1234_5678};

    RST = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; alu_res = 32'h0; next_pc = 32'h0;
    idle_in();
    @(negedge CLK);
    do_reset();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_retire_cnt", retire_cnt, 32'd0);

    // Back-to-back single-cycle writes, latency 1.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].funct, vecs[i].rt, vecs[i].rd, vecs[i].alu_res, vecs[i].next_pc);
      tick();
      chk({vecs[i].name, "_wr_en"}, 32'(wr_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        chk({vecs[i].name, "_wr_addr"}, 32'(wr_addr), 32'(vecs[i].exp_addr));
        chk({vecs[i].name, "_wr_data"}, wr_data, vecs[i].exp_data);
      end
    end
    idle_in();
    tick();
    chk("idle_wr_en", 32'(wr_en), 32'd0);

    // Loads returning after 3 cycles of WAIT_MEM.
    for (int i = 0; i < 7; i++) begin
      issue(lds[i].op, 6'h00, lds[i].rt, 5'd0, lds[i].addr, 32'h0);
      tick();
      idle_in();
      for (int c = 0; c < 3; c++) begin
        chk({lds[i].name, "_stall_ready"}, 32'(in_ready), 32'd0);
        chk({lds[i].name, "_stall_wr_en"}, 32'(wr_en), 32'd0);
        if (c == 2) begin
          mem_rvalid = 1'b1;
          mem_rdata  = lds[i].rdata;
        end
        tick();
      end
      mem_rvalid = 1'b0;
      chk({lds[i].name, "_wr_en"}, 32'(wr_en), 32'd1);
      chk({lds[i].name, "_wr_addr"}, 32'(wr_addr), 32'(lds[i].rt));
      chk({lds[i].name, "_wr_data"}, wr_data, lds[i].exp_data);
      chk({lds[i].name, "_ready"}, 32'(in_ready), 32'd1);
    end

    // Return arriving on the final timeout cycle wins; no error.
    issue(OP_LW, 6'h00, 5'd17, 5'd0, 32'h0000_2000, 32'h0);
    tick();
    idle_in();
    for (int c = 0; c < 14; c++) tick();
    chk("late_ready_low", 32'(in_ready), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("late_wr_en", 32'(wr_en), 32'd1);
    chk("late_wr_data", wr_data, 32'hCAFE_F00D);
    chk("late_err", 32'(err), 32'd0);

    // Timeout: 15 cycles without a return.
    issue(OP_LW, 6'h00, 5'd18, 5'd0, 32'h0000_3000, 32'h0);
    tick();
    idle_in();
    for (int c = 0; c < 14; c++) tick();
    chk("tmo_pre_err", 32'(err), 32'd0);
    chk("tmo_pre_ready", 32'(in_ready), 32'd0);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_wr_en", 32'(wr_en), 32'd0);
    chk("tmo_ready", 32'(in_ready), 32'd1);
    chk("tmo_wr_data_held", wr_data, 32'hCAFE_F00D);
    issue(OP_ADDI, 6'h00, 5'd5, 5'd0, 32'h0000_0005, 32'h0);
    tick();
    idle_in();
    tick();
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // Reset while waiting abandons the load.
    issue(OP_LW, 6'h00, 5'd19, 5'd0, 32'h0000_4000, 32'h0);
    tick();
    idle_in();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw_wr_en", 32'(wr_en), 32'd0);
    chk("rstw_wr_addr", 32'(wr_addr), 32'd0);
    chk("rstw_wr_data", wr_data, 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    chk("rstw_ready", 32'(in_ready), 32'd1);
    chk("rstw_retire", retire_cnt, 32'd0);

    // Retire count: 4 ADDI + 1 SW back to back.
    for (int i = 0; i < 4; i++) begin
      issue(OP_ADDI, 6'h00, 5'(i + 1), 5'd0, 32'(i), 32'h0);
      tick();
    end
    issue(OP_SW, 6'h00, 5'd2, 5'd0, 32'h0, 32'h0);
    tick();
    idle_in();
    tick();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 32'd5);
`else
    chk("retire_cnt", retire_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
